// File: rtl/aes_key_store_if.sv
// Bus bundle for the AES-128 key store: key load handshake, expander handshake and round-key read port.
// The store itself uses the slave modport; the host/expander side uses master.
interface aes_key_store_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   ks_round_num;
  logic         ks_en;
  logic [31:0]  ks_init_word_1;
  logic [31:0]  ks_init_word_2;
  logic [31:0]  ks_init_word_3;
  logic [31:0]  ks_init_word_4;
  logic         ks_done;
  logic [31:0]  ks_word_1;
  logic [31:0]  ks_word_2;
  logic [31:0]  ks_word_3;
  logic [31:0]  ks_word_4;
  logic         keys_valid;
  logic         busy;
  logic         err;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;

  modport slave (
    input  key_in, key_valid, ks_done, ks_word_1, ks_word_2, ks_word_3, ks_word_4, rd_en, rd_round,
    output key_ready, ks_round_num, ks_en, ks_init_word_1, ks_init_word_2, ks_init_word_3,
           ks_init_word_4, keys_valid, busy, err, rd_key, rd_valid, rd_err
  );

  modport master (
    output key_in, key_valid, ks_done, ks_word_1, ks_word_2, ks_word_3, ks_word_4, rd_en, rd_round,
    input  key_ready, ks_round_num, ks_en, ks_init_word_1, ks_init_word_2, ks_init_word_3,
           ks_init_word_4, keys_valid, busy, err, rd_key, rd_valid, rd_err
  );
endinterface

// File: rtl/aes_key_store.sv
// AES-128 key schedule sequencer: steps an external round-key expander through rounds 0..NUM_ROUNDS,
// captures every round key into a table and serves registered reads of stored keys.
module aes_key_store #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             areset,
  aes_key_store_if.slave   bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, GAP, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [3:0]         round_q;
  logic [3:0]         stored_cnt;
  logic [127:0]       init_q;
  logic               busy_q, err_q, keys_valid_q;
  logic               accept, ks_hit, tmo_hit, last_round;
  logic [127:0]       ks_word_all;
  logic [127:0]       key_table [0:NUM_ROUNDS];

  logic [127:0]       rd_key_p1;
  logic               rd_vld_p1, rd_err_p1;

  assign ks_word_all = {bus.ks_word_1, bus.ks_word_2, bus.ks_word_3, bus.ks_word_4};
  assign last_round  = (round_q == 4'(NUM_ROUNDS));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ks_hit    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (bus.key_valid) begin
        accept    = 1'b1;
        state_nxt = ARM;
      end
      ARM:  state_nxt = WAIT;
      WAIT: begin
        // A done arriving on the timeout cycle still wins.
        if (bus.ks_done) begin
          ks_hit    = 1'b1;
          state_nxt = GAP;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP:  state_nxt = last_round ? DONE : ARM;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      round_q      <= '0;
      stored_cnt   <= '0;
      init_q       <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARM)       wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (accept) begin
        round_q      <= '0;
        init_q       <= bus.key_in;
        stored_cnt   <= '0;
        keys_valid_q <= 1'b0;
        err_q        <= 1'b0;
        busy_q       <= 1'b1;
      end
      // The freshly produced key seeds the next round's expansion.
      if (ks_hit) begin
        init_q     <= ks_word_all;
        stored_cnt <= round_q + 4'd1;
      end
      if (tmo_hit) begin
        err_q  <= 1'b1;
        busy_q <= 1'b0;
      end
      if (state == GAP) begin
        if (last_round) begin
          keys_valid_q <= 1'b1;
          busy_q       <= 1'b0;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ks_hit && areset) key_table[round_q] <= ks_word_all;
  end

  // Read stage p1: one-cycle registered lookup, guarded by the stored count.
  always_ff @(posedge clk) begin
    if (!areset) begin
      rd_vld_p1 <= 1'b0;
      rd_err_p1 <= 1'b0;
      rd_key_p1 <= '0;
    end else begin
      rd_vld_p1 <= bus.rd_en;
      if (bus.rd_en && !(bus.rd_round > 4'(NUM_ROUNDS) || bus.rd_round >= stored_cnt)) begin
        rd_key_p1 <= key_table[bus.rd_round];
        rd_err_p1 <= 1'b0;
      end else begin
        rd_key_p1 <= '0;
        rd_err_p1 <= bus.rd_en;
      end
    end
  end

  assign bus.key_ready      = (state == IDLE);
  assign bus.ks_en          = (state == ARM) || (state == WAIT);
  assign bus.ks_round_num   = round_q;
  assign bus.ks_init_word_1 = init_q[127:96];
  assign bus.ks_init_word_2 = init_q[95:64];
  assign bus.ks_init_word_3 = init_q[63:32];
  assign bus.ks_init_word_4 = init_q[31:0];
  assign bus.keys_valid     = keys_valid_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;
  assign bus.rd_key         = rd_key_p1;
  assign bus.rd_valid       = rd_vld_p1;
  assign bus.rd_err         = rd_err_p1;
endmodule

// File: tb/tb_aes_key_store.sv
// Bench for aes_key_store: an AES-128 expander model with configurable done latency drives the store,
// and stored keys are compared against a key schedule computed directly from the cipher key.
module tb_aes_key_store;
  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  aes_key_store_if bus();
  aes_key_store #(.NUM_ROUNDS(10), .TIMEOUT(64)) dut (.clk(clk), .areset(areset), .bus(bus));

  logic         exp_done = 1'b0, man_done = 1'b0;
  logic [127:0] exp_words = '0, man_words = '0;
  int           lat = 1;
  int           stall_round = -1;
  bit           exp_on = 1'b1;
  int           n_checks = 0, n_pass = 0;
  logic [127:0] ref_keys [0:10];

  assign bus.ks_done = exp_done | man_done;
  assign {bus.ks_word_1, bus.ks_word_2, bus.ks_word_3, bus.ks_word_4} = man_done ? man_words : exp_words;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] k, input int r);
    logic [31:0] w1, w2, w3, w4, t;
    logic [7:0]  rc = 8'h01;
    {w1, w2, w3, w4} = k;
    t = {w4[23:0], w4[31:24]};
    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    for (int i = 1; i < r; i++) rc = xtime(rc);
    t  = t ^ {rc, 24'h0};
    w1 = w1 ^ t;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    w4 = w4 ^ w3;
    return {w1, w2, w3, w4};
  endfunction

  task automatic build_ref(input logic [127:0] k);
    ref_keys[0] = k;
    for (int r = 1; r <= 10; r++) ref_keys[r] = next_round_key(ref_keys[r-1], r);
  endtask

  // Expander model: done arrives after the enable has been seen for lat+1 cycles.
  initial begin : expander
    int en_cnt;
    logic [127:0] init;
    en_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      if (!bus.ks_en) en_cnt = 0;
      else en_cnt++;
      if (exp_on && bus.ks_en && en_cnt == lat + 2 && int'(bus.ks_round_num) != stall_round) begin
        init = {bus.ks_init_word_1, bus.ks_init_word_2, bus.ks_init_word_3, bus.ks_init_word_4};
        exp_words = (bus.ks_round_num == 4'd0) ? init : next_round_key(init, int'(bus.ks_round_num));
        exp_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_key(input logic [127:0] k);
    int n = 0;
    @(negedge clk);
    while (!bus.key_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_kv(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!bus.keys_valid && cyc < 400);
  endtask

  task automatic rd(input logic [3:0] idx, output logic [127:0] k, output logic v, output logic e);
    bus.rd_en    = 1'b1;
    bus.rd_round = idx;
    @(negedge clk);
    bus.rd_en = 1'b0;
    k = bus.rd_key;
    v = bus.rd_valid;
    e = bus.rd_err;
  endtask

  task automatic check_read(input string tag, input int idx, input int n_stored);
    logic [127:0] k;
    logic v, e;
    logic bad;
    bad = (idx > 10) || (idx >= n_stored);
    rd(4'(idx), k, v, e);
    check($sformatf("%s_vld_err[%0d]", tag, idx), {126'h0, v, e}, {126'h0, 1'b1, bad});
    check($sformatf("%s_key[%0d]", tag, idx), k, bad ? 128'h0 : ref_keys[idx]);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i <= 10; i++) check_read(tag, i, 11);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_key_ready"}, 128'(bus.key_ready), 128'(1));
    check({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check({tag, "_ks_en"}, 128'(bus.ks_en), 128'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc, n_en3, n_v;
    logic [127:0] ka, kb, k;
    logic v, e;
    bus.key_in = '0; bus.key_valid = 1'b0; bus.rd_en = 1'b0; bus.rd_round = '0;

    areset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_flags", {125'h0, bus.keys_valid, bus.err, bus.rd_valid}, 128'h0);
    check("rst_round", 128'(bus.ks_round_num), 128'h0);
    check("rst_init", {bus.ks_init_word_1, bus.ks_init_word_2, bus.ks_init_word_3, bus.ks_init_word_4}, 128'h0);
    areset = 1'b1;

    // FIPS-197 key, one-cycle expander latency
    lat = 1;
    build_ref(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_kv(cyc);
    check("fips_kv_cycles", 128'(cyc), 128'(44));
    check("fips_busy_done", 128'(bus.busy), 128'(0));
    rd(4'd0, k, v, e);
    check("fips_r0", k, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(4'd1, k, v, e);
    check("fips_r1", k, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, k, v, e);
    check("fips_r10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_table("fips");

    // Random key, seven-cycle latency
    lat = 7;
    ka = rand_key();
    build_ref(ka);
    start_key(ka);
    wait_kv(cyc);
    check("lat7_kv_cycles", 128'(cyc), 128'(110));
    check_table("lat7");

    // Random key, random latency, random reads including out-of-range indices
    lat = int'($urandom_range(1, 5));
    ka = rand_key();
    build_ref(ka);
    start_key(ka);
    wait_kv(cyc);
    check("rlat_kv_cycles", 128'(cyc), 128'(11 * (lat + 3)));
    for (int i = 0; i < 6; i++) check_read("rnd", int'($urandom_range(0, 15)), 11);

    // Expander stalls in round 3 until the store gives up
    lat = 1;
    stall_round = 3;
    ka = rand_key();
    build_ref(ka);
    start_key(ka);
    n_en3 = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.ks_en && bus.ks_round_num == 4'd3) n_en3++;
    end while (!bus.err && cyc < 300);
    stall_round = -1;
    check("tmo_en_cycles", 128'(n_en3), 128'(65));
    check("tmo_err", 128'(bus.err), 128'(1));
    check("tmo_kv", 128'(bus.keys_valid), 128'(0));
    check_idle("tmo");
    check_read("tmo", 2, 3);
    check_read("tmo", 3, 3);

    // Second key offered while busy is ignored; err clears on accept
    ka = rand_key();
    kb = rand_key();
    build_ref(ka);
    start_key(ka);
    check("acc_err_clear", 128'(bus.err), 128'(0));
    bus.key_in = kb;
    bus.key_valid = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_mid", {126'h0, bus.busy, bus.key_ready}, 128'b10);
    bus.key_valid = 1'b0;
    wait_kv(cyc);
    check("ign_kv", 128'(bus.keys_valid), 128'(1));
    check_table("ign");
    ka = rand_key();
    build_ref(ka);
    start_key(ka);
    check("kv_drop", 128'(bus.keys_valid), 128'(0));
    check("busy_set", 128'(bus.busy), 128'(1));
    wait_kv(cyc);
    check("second_kv_cycles", 128'(cyc), 128'(44));
    check_table("second");

    // Reset in the middle of round 5, then a stale done pulse
    lat = 7;
    start_key(rand_key());
    cyc = 0;
    while (!(bus.ks_en && bus.ks_round_num == 4'd5) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_r5", 128'(bus.ks_round_num), 128'(5));
    @(negedge clk);
    exp_on = 1'b0;
    areset = 1'b0;
    @(negedge clk);
    check_idle("mrst");
    check("mrst_flags", {125'h0, bus.keys_valid, bus.err, bus.rd_valid}, 128'h0);
    check("mrst_round", 128'(bus.ks_round_num), 128'h0);
    areset = 1'b1;
    man_words = rand_key();
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check_idle("stale");
    check_read("mrst", 0, 0);
    exp_on = 1'b1;

    // Full table, then out-of-range and back-to-back reads
    lat = 1;
    ka = rand_key();
    build_ref(ka);
    start_key(ka);
    wait_kv(cyc);
    check_read("oor", 11, 11);
    check_read("oor", 15, 11);
    n_v = 0;
    bus.rd_en = 1'b1;
    bus.rd_round = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rd_valid) n_v++;
      check($sformatf("b2b_key[%0d]", i), bus.rd_key, ref_keys[i]);
      bus.rd_round = 4'(i + 1);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    if (bus.rd_valid) n_v++;
    check("b2b_count", 128'(n_v), 128'(5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
